// File: rtl/execute_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO registers: one product or quotient
// bit per cycle, followed by a single sign-fixup cycle that commits HI/LO.
module execute_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               isDiv_q, isDiv_d;
  logic               negLo_q, negLo_d;
  logic               negHi_q, negHi_d;
  logic               divZero_q, divZero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               isSigned;
  logic [WIDTH-1:0]   absA, absB;
  logic [WIDTH:0]     mulSum, divShift, divDiff;
  logic [2*WIDTH-1:0] mulNext, divNext, prodFix;
  logic [WIDTH-1:0]   quotFix, remFix;

  // acc_q upper half is the partial product / partial remainder, lower half the
  // multiplier being shifted out or the dividend being shifted into quotient bits.
  always_comb begin
    isSigned = (op_i == 3'd0) || (op_i == 3'd2);
    absA     = (isSigned && a_i[WIDTH-1]) ? -a_i : a_i;
    absB     = (isSigned && b_i[WIDTH-1]) ? -b_i : b_i;

    mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    mulNext  = {mulSum, acc_q[WIDTH-1:1]};

    divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    divDiff  = divShift - {1'b0, mcand_q};
    divNext  = divDiff[WIDTH] ? {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                              : {divDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    prodFix  = negLo_q ? -acc_q : acc_q;
    quotFix  = negLo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    remFix   = negHi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state logic; flush beats start, and a flushed operation never commits.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    isDiv_d   = isDiv_q;
    negLo_d   = negLo_q;
    negHi_d   = negHi_q;
    divZero_d = divZero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          case (op_i)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              isDiv_d   = op_i[1];
              acc_d     = {{WIDTH{1'b0}}, (op_i[1] ? absA : absB)};
              mcand_d   = op_i[1] ? absB : absA;
              negLo_d   = isSigned && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
              negHi_d   = isSigned && a_i[WIDTH-1];
              divZero_d = op_i[1] && (b_i == '0);
              cnt_d     = CNT_W'(WIDTH);
              state_d   = CALC;
            end
            3'd4:    hi_d = a_i;
            3'd5:    lo_d = a_i;
            default: ;
          endcase
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d = isDiv_q ? divNext : mulNext;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush_i) begin
          // Divide by zero yields an all-ones quotient; the remainder path already returns a_i.
          hi_d   = isDiv_q ? remFix : prodFix[2*WIDTH-1:WIDTH];
          lo_d   = isDiv_q ? (divZero_q ? {WIDTH{1'b1}} : quotFix) : prodFix[WIDTH-1:0];
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      isDiv_q   <= 1'b0;
      negLo_q   <= 1'b0;
      negHi_q   <= 1'b0;
      divZero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      isDiv_q   <= isDiv_d;
      negLo_q   <= negLo_d;
      negHi_q   <= negHi_d;
      divZero_q <= divZero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Scoreboard bench for execute_muldiv: a 32-bit instance driven with directed and random
// operations, plus an 8-bit instance for the narrow-width latency case.
module tb_execute_muldiv;

  localparam int W  = 32;
  localparam int W8 = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, flush;
  logic [2:0]   op;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done;

  logic          start8, flush8;
  logic [2:0]    op8;
  logic [W8-1:0] a8, b8, hi8, lo8;
  logic          busy8, done8;

  always #5 clk = ~clk;

  execute_muldiv #(.WIDTH(W)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .flush_i(flush), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  execute_muldiv #(.WIDTH(W8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .op_i(op8), .a_i(a8), .b_i(b8),
    .flush_i(flush8), .busy_o(busy8), .done_o(done8), .hi_o(hi8), .lo_o(lo8)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           doneEdge;
  } expect_t;

  expect_t      sbQueue[$];
  expect_t      monEntry;
  int           testsRun = 0;
  int           testsFailed = 0;
  int           cycleCount = 0;
  int           busyRun = 0;
  logic [W-1:0] modelHi = '0;
  logic [W-1:0] modelLo = '0;

  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour built from plain SystemVerilog arithmetic; returns {hi, lo}.
  function automatic logic [63:0] modelMulDiv(input logic [2:0] mOp, input logic [W-1:0] x,
                                               input logic [W-1:0] y);
    logic signed [63:0] sx, sy;
    int sq, sr;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    case (mOp)
      3'd0: return sx * sy;
      3'd1: return {32'b0, x} * {32'b0, y};
      3'd2: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        sq = $signed(x) / $signed(y);
        sr = $signed(x) % $signed(y);
        return {sr, sq};
      end
      3'd3: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Result monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (rst) begin
      if (done) begin
        if (sbQueue.size() == 0) begin
          checkOutput("unexpected done", 64'(done), 64'(0));
        end else begin
          monEntry = sbQueue.pop_front();
          checkOutput("hi", 64'(hi), 64'(monEntry.hi));
          checkOutput("lo", 64'(lo), 64'(monEntry.lo));
          checkOutput("done edge", 64'(cycleCount), 64'(monEntry.doneEdge));
          checkOutput("busy cycles", 64'(busyRun), 64'(W + 1));
          modelHi = monEntry.hi;
          modelLo = monEntry.lo;
        end
        busyRun = 0;
      end else if (busy) begin
        busyRun++;
      end else begin
        busyRun = 0;
      end
    end
  end

  // Waits for idle, issues one request, and records what the DUT must produce.
  task automatic applyStimulus(input logic [2:0] sOp, input logic [W-1:0] sA, input logic [W-1:0] sB);
    logic [63:0] res;
    expect_t entry;
    int waitCount = 0;
    @(negedge clk);
    while (busy && waitCount < 200) begin
      @(negedge clk);
      waitCount++;
    end
    if (busy) checkOutput("idle timeout", 64'(busy), 64'(0));
    start = 1'b1;
    op    = sOp;
    a     = sA;
    b     = sB;
    if (sOp <= 3'd3) begin
      res = modelMulDiv(sOp, sA, sB);
      entry.hi = res[63:32];
      entry.lo = res[31:0];
      entry.doneEdge = cycleCount + W + 2;
      sbQueue.push_back(entry);
    end
    @(negedge clk);
    start = 1'b0;
    if (sOp == 3'd4) modelHi = sA;
    if (sOp == 3'd5) modelLo = sA;
  endtask

  task automatic drainQueue();
    for (int i = 0; i < 200 && sbQueue.size() != 0; i++) @(negedge clk);
    checkOutput("drain", 64'(sbQueue.size()), 64'(0));
  endtask

  initial begin
    int doneSeen;
    int startEdge;
    int busyCount;
    rst = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; flush8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 64'(busy), 64'(0));
    checkOutput("reset done", 64'(done), 64'(0));
    checkOutput("reset hi", 64'(hi), 64'(0));
    checkOutput("reset lo", 64'(lo), 64'(0));
    rst = 1'b1;

    applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    applyStimulus(3'd0, 32'hFFFFFFFD, 32'd5);
    applyStimulus(3'd2, 32'hFFFFFFF9, 32'd2);
    applyStimulus(3'd3, 32'h12345678, 32'd0);
    applyStimulus(3'd2, 32'h80000000, 32'hFFFFFFFF);
    applyStimulus(3'd2, 32'hFFFFFFFB, 32'd0);
    applyStimulus(3'd0, 32'h80000000, 32'h80000000);
    applyStimulus(3'd2, 32'd7, 32'hFFFFFFFE);
    applyStimulus(3'd3, 32'hFFFFFFFF, 32'd1);
    for (int i = 0; i < 8; i++) applyStimulus(3'($urandom_range(0, 3)), $urandom, $urandom);
    drainQueue();

    // Flush in the 10th CALC cycle must abandon the multiply.
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'h00001234; b = 32'h00005678;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush busy", 64'(busy), 64'(0));
    checkOutput("flush done", 64'(done), 64'(0));
    checkOutput("flush hold", {hi, lo}, {modelHi, modelLo});
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("flush no done", 64'(doneSeen), 64'(0));

    applyStimulus(3'd4, 32'hA5A5A5A5, 32'h0);
    checkOutput("mthi hi", 64'(hi), 64'(32'hA5A5A5A5));
    checkOutput("mthi busy", 64'(busy), 64'(0));
    applyStimulus(3'd5, 32'h00C0FFEE, 32'h0);
    checkOutput("mtlo regs", {hi, lo}, {modelHi, modelLo});
    applyStimulus(3'd6, 32'hDEADBEEF, 32'h1);
    checkOutput("noop busy", 64'(busy), 64'(0));
    checkOutput("noop regs", {hi, lo}, {modelHi, modelLo});

    // Flush together with MTHI in IDLE blocks the write.
    start = 1'b1; op = 3'd4; a = 32'h11111111; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checkOutput("flush mthi", 64'(hi), 64'(modelHi));

    // Reset in the middle of a DIVU.
    start = 1'b1; op = 3'd3; a = 32'h0000F00D; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("midreset busy", 64'(busy), 64'(0));
    checkOutput("midreset done", 64'(done), 64'(0));
    checkOutput("midreset hilo", {hi, lo}, 64'(0));
    modelHi = '0;
    modelLo = '0;
    repeat (40) @(negedge clk);

    // Narrow instance: MULTU 0xFF * 0xFF.
    start8 = 1'b1; op8 = 3'd1; a8 = 8'hFF; b8 = 8'hFF;
    startEdge = cycleCount + 1;
    @(negedge clk);
    start8 = 1'b0;
    busyCount = 0;
    for (int i = 0; i < 40 && !done8; i++) begin
      if (busy8) busyCount++;
      @(negedge clk);
    end
    checkOutput("w8 done", 64'(done8), 64'(1));
    checkOutput("w8 done edge", 64'(cycleCount), 64'(startEdge + W8 + 1));
    checkOutput("w8 busy cycles", 64'(busyCount), 64'(W8 + 1));
    checkOutput("w8 hi", 64'(hi8), 64'(8'hFE));
    checkOutput("w8 lo", 64'(lo8), 64'(8'h01));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/execute_muldiv.md
Name: execute_muldiv

Overview:
- Parametrised multi-cycle multiply/divide unit that sits beside the execute-stage ALU and owns the HI/LO architectural registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage and raises a stall (busy) while an iterative operation is in flight.
- Generalises the single-cycle ALU path to a WIDTH-bit, one-bit-per-cycle shift-add / restoring-divide datapath with flush support.

Parameters:
- WIDTH, 32, operand and HI/LO width; legal range 4..64.
- CNT_W, $clog2(WIDTH)+1, iteration counter width. Derived; do not override.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset; synchronous, active-low.
- start_i  input  1  operation request, sampled only in IDLE.
- op_i  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are no-ops.
- a_i  input  WIDTH  rs operand (already forwarded); multiplicand, dividend, or MTHI/MTLO data.
- b_i  input  WIDTH  rt operand (already forwarded); multiplier or divisor.
- flush_i  input  1  abort the in-flight operation.
- busy_o  output  1  high whenever state != IDLE; drives the hazard-unit stall.
- done_o  output  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- hi_o  output  WIDTH  HI register.
- lo_o  output  WIDTH  LO register.

Behaviour:
- Reset (rst_i=0 at an edge):
  - state is IDLE, counter is 0, and the internal accumulator, quotient and sign flags are cleared.
  - hi_o=0, lo_o=0, busy_o=0, done_o=0.
  - Reset overrides every other input, including mid-operation.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - start_i=1 with op 0..3: latch the operand magnitudes and result-sign flags, load counter=WIDTH, go to CALC.
  - start_i=1 with op 4 or 5: write a_i to HI or LO at that edge and stay in IDLE. done_o stays 0 and busy_o never rises.
  - Op 6 or 7: ignored.
- Operand magnitudes and signs:
  - Signed ops (MULT/DIV) take magnitudes as two's-complement absolute values, treated as unsigned WIDTH bits, so |INT_MIN| = 2^(WIDTH-1).
  - Unsigned ops use the operands as-is.
  - Product sign = sign(a) XOR sign(b).
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- CALC: exactly WIDTH cycles, counter decrements by 1 each cycle.
  - Multiply: shift-add, one multiplier bit per cycle, 2*WIDTH-bit unsigned product.
  - Divide: restoring, one quotient bit per cycle.
  - Counter==1 moves to FIX.
- FIX (1 cycle):
  - Apply sign correction and write HI/LO at the end of the cycle.
  - Multiply: HI = upper WIDTH bits, LO = lower WIDTH bits.
  - Divide: LO = quotient, HI = remainder.
  - Next state is IDLE; done_o is registered high in the following cycle.
- Latency: start sampled at edge N gives:
  - busy_o high in cycles N+1 .. N+WIDTH+1;
  - done_o high and new HI/LO visible in cycle N+WIDTH+2;
  - busy_o low in cycle N+WIDTH+2.
  - A new start_i may be accepted at the edge ending cycle N+WIDTH+2 (back-to-back with done_o).
- Divide by zero (b_i=0, DIV or DIVU): run the full WIDTH+1 cycles; result LO = all ones, HI = a_i unchanged (original signed value).
- Signed overflow (INT_MIN / -1): LO = INT_MIN, HI = 0. This falls out of the magnitude algorithm with no special case.
- start_i while busy_o=1: ignored. Upstream holds the instruction via the stall.
- flush_i=1 in CALC or FIX:
  - Return to IDLE at that edge; HI/LO keep their old values; no done_o.
  - flush_i in IDLE together with start_i: flush wins, and nothing is latched or written (MTHI/MTLO included).
- hi_o and lo_o change only at a FIX completion, an MTHI/MTLO write, or reset.

Test Plan:
- Timing and unsigned multiply: WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF at edge N.
  - busy_o high for 33 cycles.
  - At N+34: done_o=1, HI=0xFFFFFFFE, LO=0x00000001.
- Signed ops:
  - MULT a=0xFFFFFFFD (-3), b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - DIV a=0xFFFFFFF9 (-7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Corner divides:
  - DIVU a=0x12345678, b=0 → LO=0xFFFFFFFF, HI=0x12345678.
  - DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- Flush and MTHI:
  - Start MULT, assert flush_i in the 10th CALC cycle → busy_o=0 next cycle, no done_o, HI/LO unchanged.
  - Then MTHI a=0xA5A5A5A5 → HI=0xA5A5A5A5 after one edge, busy_o never rises.
- Reset mid-operation:
  - Start DIVU, drive rst_i=0 for one edge mid-CALC → next cycle busy_o=0, done_o=0, HI=LO=0.
  - Repeat the MULTU case with WIDTH=8: a=0xFF, b=0xFF → HI=0xFE, LO=0x01, done_o at N+10.
